// File: rtl/draft_pkg.sv
// Shared types and constants for the uio pin-bank arbiter.
package draft_pkg;

    localparam int   PIN_W  = 8;
    localparam logic DIR_WR = 1'b1;
    localparam logic DIR_RD = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TURN   = 2'd1,
        ACTIVE = 2'd2
    } arb_state_t;

    function automatic logic [PIN_W-1:0] oe_mask(input logic d);
        return (d == DIR_WR) ? {PIN_W{1'b1}} : {PIN_W{1'b0}};
    endfunction

endpackage

// File: rtl/draft_uio_arbiter_if.sv
// Requester/pin bundle of the uio arbiter; the lock vector exists only when
// DRAFT_ARB_LOCK_EN is defined.
interface draft_uio_arbiter_if #(
    parameter int N_REQ = 4
);
    import draft_pkg::*;

    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       dir;
    logic [N_REQ-1:0]       last;
    logic [PIN_W*N_REQ-1:0] wdata;
    logic [PIN_W-1:0]       uio_in;
    logic [PIN_W-1:0]       uio_out;
    logic [PIN_W-1:0]       uio_oe;
    logic [N_REQ-1:0]       gnt;
    logic [PIN_W-1:0]       rd_data;
    logic                   rd_valid;
    logic                   busy;
    arb_state_t             dbg_state;
    logic [IW-1:0]          dbg_rr_ptr;
`ifdef DRAFT_ARB_LOCK_EN
    logic [N_REQ-1:0]       lock;

    modport master (output req, dir, last, wdata, uio_in, lock,
                    input  uio_out, uio_oe, gnt, rd_data, rd_valid, busy, dbg_state, dbg_rr_ptr);
    modport slave  (input  req, dir, last, wdata, uio_in, lock,
                    output uio_out, uio_oe, gnt, rd_data, rd_valid, busy, dbg_state, dbg_rr_ptr);
`else
    modport master (output req, dir, last, wdata, uio_in,
                    input  uio_out, uio_oe, gnt, rd_data, rd_valid, busy, dbg_state, dbg_rr_ptr);
    modport slave  (input  req, dir, last, wdata, uio_in,
                    output uio_out, uio_oe, gnt, rd_data, rd_valid, busy, dbg_state, dbg_rr_ptr);
`endif

endinterface

// File: rtl/draft_rr_pick.sv
// Round-robin picker: first asserted request at or after i_ptr, wrapping mod N_REQ.
module draft_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [IW-1:0]    o_idx,
    output logic             o_valid
);

    logic [IW:0] w_sum;

    // Scan from the farthest offset down so the nearest request wins.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_sum   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N_REQ)) begin
                w_sum = w_sum - (IW+1)'(N_REQ);
            end
            if (i_req[w_sum[IW-1:0]]) begin
                o_idx   = w_sum[IW-1:0];
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/draft_uio_arbiter.sv
// Round-robin burst arbiter for the shared 8-bit uio pin bank, with bus
// turnaround on direction change. Optional DRAFT_ARB_LOCK_EN adds per-requester burst lock.
module draft_uio_arbiter
    import draft_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int BURST_MAX = 8,
    parameter int TURN_CYC  = 1
) (
    input  logic               clk,
    input  logic               rst,
    draft_uio_arbiter_if.slave bus
);

    localparam int               IW        = $clog2(N_REQ);
    localparam logic [3:0]       BEAT_LAST = 4'(BURST_MAX - 1);
    localparam logic [1:0]       TURN_LAST = (TURN_CYC > 0) ? 2'(TURN_CYC - 1) : 2'd0;
    localparam logic [IW-1:0]    PTR_MAX   = IW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);

    arb_state_t       r_state;
    logic [IW-1:0]    r_g;
    logic [IW-1:0]    r_rr_ptr;
    logic             r_d;
    logic             r_last_dir;
    logic [3:0]       r_beat_cnt;
    logic [1:0]       r_turn_cnt;
    logic [N_REQ-1:0] r_req;
    logic [N_REQ-1:0] r_gnt;
    logic [PIN_W-1:0] r_uio_out;
    logic [PIN_W-1:0] r_uio_oe;
    logic [PIN_W-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             r_busy;

    logic [IW-1:0]    w_pick_idx;
    logic             w_pick_valid;
    logic [IW-1:0]    w_sel;
    logic             w_sel_dir;
    logic [PIN_W-1:0] w_sel_wdata;
    logic             w_req_g;
    logic             w_limit;
    logic [3:0]       w_beat_nxt;
    logic [IW-1:0]    w_ptr_nxt;
    logic [N_REQ-1:0] w_req_seen;

    // A request must be seen on two consecutive edges; this also drops a stale
    // request from a requester that released right after its last beat.
    assign w_req_seen = r_req & bus.req;

    draft_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .i_req   (w_req_seen),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    always_comb begin
        w_sel       = (r_state == IDLE) ? w_pick_idx : r_g;
        w_sel_dir   = (r_state == IDLE) ? bus.dir[w_pick_idx] : r_d;
        w_sel_wdata = bus.wdata[PIN_W*w_sel +: PIN_W];
        w_req_g     = bus.req[r_g];
`ifdef DRAFT_ARB_LOCK_EN
        w_limit     = (r_beat_cnt == BEAT_LAST) && !bus.lock[r_g];
`else
        w_limit     = (r_beat_cnt == BEAT_LAST);
`endif
        w_beat_nxt  = (r_beat_cnt == BEAT_LAST) ? r_beat_cnt : r_beat_cnt + 4'd1;
        w_ptr_nxt   = (r_g == PTR_MAX) ? '0 : r_g + IW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_g        <= '0;
            r_rr_ptr   <= '0;
            r_d        <= 1'b0;
            r_last_dir <= 1'b0;
            r_beat_cnt <= '0;
            r_turn_cnt <= '0;
            r_req      <= '0;
            r_gnt      <= '0;
            r_uio_out  <= '0;
            r_uio_oe   <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_req      <= bus.req;
            r_rd_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_g        <= w_pick_idx;
                        r_d        <= w_sel_dir;
                        r_busy     <= 1'b1;
                        r_beat_cnt <= '0;
                        if (TURN_CYC > 0 && w_sel_dir != r_last_dir) begin
                            r_state    <= TURN;
                            r_turn_cnt <= '0;
                        end else begin
                            r_state   <= ACTIVE;
                            r_gnt     <= ONE_HOT0 << w_sel;
                            r_uio_oe  <= oe_mask(w_sel_dir);
                            r_uio_out <= (w_sel_dir == DIR_WR) ? w_sel_wdata : '0;
                        end
                    end
                end
                TURN: begin
                    if (r_turn_cnt == TURN_LAST) begin
                        r_state   <= ACTIVE;
                        r_gnt     <= ONE_HOT0 << w_sel;
                        r_uio_oe  <= oe_mask(w_sel_dir);
                        r_uio_out <= (w_sel_dir == DIR_WR) ? w_sel_wdata : '0;
                    end else begin
                        r_turn_cnt <= r_turn_cnt + 2'd1;
                    end
                end
                ACTIVE: begin
                    if (w_req_g && !bus.last[r_g] && !w_limit) begin
                        r_beat_cnt <= w_beat_nxt;
                        r_uio_out  <= (r_d == DIR_WR) ? w_sel_wdata : '0;
                    end else begin
                        r_state    <= IDLE;
                        r_rr_ptr   <= w_ptr_nxt;
                        r_last_dir <= r_d;
                        r_beat_cnt <= '0;
                        r_gnt      <= '0;
                        r_uio_oe   <= '0;
                        r_uio_out  <= '0;
                        r_busy     <= 1'b0;
                    end
                    // A cycle whose requester has already dropped is an abort, not a beat.
                    if (w_req_g && r_d == DIR_RD) begin
                        r_rd_data  <= bus.uio_in;
                        r_rd_valid <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.uio_out    = r_uio_out;
    assign bus.uio_oe     = r_uio_oe;
    assign bus.rd_data    = r_rd_data;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.busy       = r_busy;
    assign bus.dbg_state  = r_state;
    assign bus.dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_draft_uio_arbiter.sv
// Directed bench for draft_uio_arbiter (N_REQ=4, BURST_MAX=8, TURN_CYC=1);
// the lock scenario is included when DRAFT_ARB_LOCK_EN is defined.
module tb_draft_uio_arbiter;
    import draft_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    int   n_beats;
    logic [3:0] exp_q[$];
    logic [3:0] exp_idx;

    draft_uio_arbiter_if #(.N_REQ(4)) bus ();

    draft_uio_arbiter #(.N_REQ(4), .BURST_MAX(8), .TURN_CYC(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'h0);
        chk({tag, "_oe"}, 32'(bus.uio_oe), 32'h0);
        chk({tag, "_out"}, 32'(bus.uio_out), 32'h0);
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.req  = '0;
        bus.dir  = '0;
        bus.last = '0;
        bus.wdata = '0;
        bus.uio_in = '0;
`ifdef DRAFT_ARB_LOCK_EN
        bus.lock = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        // reset state
        chk_idle_outputs("rst");
        chk("rst_rd_data", 32'(bus.rd_data), 32'h0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_state", 32'(bus.dbg_state), 32'(IDLE));
        chk("rst_ptr", 32'(bus.dbg_rr_ptr), 32'h0);
        rst = 1'b0;

        // single writer on requester 1, reversal from reset direction -> TURN
        bus.req[1] = 1'b1;
        bus.dir[1] = 1'b1;
        bus.wdata[15:8] = 8'hA5;
        step();
        chk("sw_wait_state", 32'(bus.dbg_state), 32'(IDLE));
        step();
        chk("sw_turn_state", 32'(bus.dbg_state), 32'(TURN));
        chk_idle_outputs("sw_turn");
        chk("sw_turn_busy", 32'(bus.busy), 32'h1);
        step();
        chk("sw_b1_gnt", 32'(bus.gnt), 32'h2);
        chk("sw_b1_oe", 32'(bus.uio_oe), 32'hFF);
        chk("sw_b1_out", 32'(bus.uio_out), 32'hA5);
        bus.wdata[7:0] = 8'hEE;
        bus.dir[0] = 1'b0;
        step();
        chk("sw_b2_gnt", 32'(bus.gnt), 32'h2);
        chk("sw_b2_out", 32'(bus.uio_out), 32'hA5);
        step();
        chk("sw_b3_gnt", 32'(bus.gnt), 32'h2);
        bus.last[1] = 1'b1;
        step();
        chk_idle_outputs("sw_done");
        chk("sw_done_ptr", 32'(bus.dbg_rr_ptr), 32'h2);
        chk("sw_done_busy", 32'(bus.busy), 32'h0);
        bus.req[1] = 1'b0;
        bus.last[1] = 1'b0;

        // burst limit on requester 0, same direction -> no TURN
        bus.req[0] = 1'b1;
        bus.dir[0] = 1'b1;
        bus.wdata[7:0] = 8'h11;
        step();
        step();
        chk("bl_first_gnt", 32'(bus.gnt), 32'h1);
        chk("bl_first_out", 32'(bus.uio_out), 32'h11);
        n_beats = 0;
        for (int i = 0; i < 20 && bus.gnt == 4'b0001; i++) begin
            n_beats++;
            step();
        end
        chk("bl_beats", 32'(n_beats), 32'd8);
        chk("bl_gap_state", 32'(bus.dbg_state), 32'(IDLE));
        chk_idle_outputs("bl_gap");
        step();
        chk("bl_regrant_gnt", 32'(bus.gnt), 32'h1);
        // abort: drop req mid-burst
        bus.req[0] = 1'b0;
        step();
        chk_idle_outputs("abort");
        chk("abort_state", 32'(bus.dbg_state), 32'(IDLE));
        chk("abort_ptr", 32'(bus.dbg_rr_ptr), 32'h1);

        // turnaround: write on 0, then read on 2
        bus.req[0] = 1'b1;
        bus.last[0] = 1'b1;
        bus.wdata[7:0] = 8'hC3;
        step();
        step();
        chk("ta_wr_gnt", 32'(bus.gnt), 32'h1);
        chk("ta_wr_out", 32'(bus.uio_out), 32'hC3);
        bus.req[2] = 1'b1;
        bus.dir[2] = 1'b0;
        bus.last[2] = 1'b1;
        step();
        chk("ta_idle_state", 32'(bus.dbg_state), 32'(IDLE));
        chk_idle_outputs("ta_idle");
        bus.req[0] = 1'b0;
        bus.last[0] = 1'b0;
        step();
        chk("ta_turn_state", 32'(bus.dbg_state), 32'(TURN));
        chk_idle_outputs("ta_turn");
        step();
        chk("ta_rd_gnt", 32'(bus.gnt), 32'h4);
        chk("ta_rd_oe", 32'(bus.uio_oe), 32'h0);
        chk("ta_rd_valid_pre", 32'(bus.rd_valid), 32'h0);
        bus.uio_in = 8'h3C;
        step();
        chk("ta_rd_valid", 32'(bus.rd_valid), 32'h1);
        chk("ta_rd_data", 32'(bus.rd_data), 32'h3C);
        chk("ta_rd_end_gnt", 32'(bus.gnt), 32'h0);
        bus.req[2] = 1'b0;
        bus.last[2] = 1'b0;
        step();
        chk("ta_rd_valid_post", 32'(bus.rd_valid), 32'h0);
        chk("ta_ptr", 32'(bus.dbg_rr_ptr), 32'h3);

        // asynchronous reset in the middle of a write burst
        bus.req[3] = 1'b1;
        bus.dir[3] = 1'b1;
        bus.wdata[31:24] = 8'h77;
        step();
        step();
        step();
        chk("rm_gnt_before", 32'(bus.gnt), 32'h8);
        chk("rm_oe_before", 32'(bus.uio_oe), 32'hFF);
        #3;
        rst = 1'b1;
        #1;
        chk_idle_outputs("rm_async");
        chk("rm_busy", 32'(bus.busy), 32'h0);
        chk("rm_state", 32'(bus.dbg_state), 32'(IDLE));
        bus.req[3] = 1'b0;
        bus.dir[3] = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("rm_ptr", 32'(bus.dbg_rr_ptr), 32'h0);

        // fairness: all request reads, each ends on its first beat
        bus.req  = 4'b1111;
        bus.dir  = 4'b0000;
        bus.last = 4'b1111;
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd0);
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            exp_idx = exp_q.pop_front();
            chk($sformatf("fair_gnt%0d", k), 32'(bus.gnt), 32'(4'b0001 << exp_idx));
            bus.uio_in = 8'h40 + 8'(k);
            step();
            chk($sformatf("fair_gap%0d", k), 32'(bus.gnt), 32'h0);
            chk($sformatf("fair_rdv%0d", k), 32'(bus.rd_valid), 32'h1);
            chk($sformatf("fair_rdd%0d", k), 32'(bus.rd_data), 32'h40 + 32'(k));
        end
        bus.req  = '0;
        bus.last = '0;
        step();
        chk("fair_end_ptr", 32'(bus.dbg_rr_ptr), 32'h1);

`ifdef DRAFT_ARB_LOCK_EN
        // lock holds the grant past BURST_MAX until last
        bus.lock[0] = 1'b1;
        bus.req[0]  = 1'b1;
        step();
        step();
        for (int b = 1; b <= 12; b++) begin
            chk($sformatf("lock_beat%0d", b), 32'(bus.gnt), 32'h1);
            if (b == 12) bus.last[0] = 1'b1;
            step();
        end
        chk("lock_end_gnt", 32'(bus.gnt), 32'h0);
        bus.req[0]  = 1'b0;
        bus.last[0] = 1'b0;
        bus.lock[0] = 1'b0;
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
